// File: rtl/unique_4_serializer.sv
// unique_4_serializer
// Snapshots the four unique-value slots on a start request and streams the
// valid entries, lowest slot first, onto a single valid/ready byte channel.
// Optional build macro: UNIQUE_SER_PARITY_EN adds the m_parity output
// (even parity of m_data, registered alongside it, 0 while m_valid is low).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; snapshot taken when start is sampled
// SEND  | presenting snapshot entries; advance on each handshake
module unique_4_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic [1:0]        in_valid_0,
    input  logic [1:0]        in_valid_1,
    input  logic [1:0]        in_valid_2,
    input  logic [1:0]        in_valid_3,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic              busy,
    output logic [2:0]        snap_cnt,
    output logic              empty_snap,
    output logic              done
`ifdef UNIQUE_SER_PARITY_EN
    ,
    output logic              m_parity
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] snap_data [4];
    // Valid slots of the snapshot that have not been presented yet.
    logic [3:0]        pend;

    logic [DATA_W-1:0] in_arr [4];
    logic [3:0]        in_mask;
    logic [2:0]        in_cnt;
    logic [1:0]        in_idx;
    logic [3:0]        in_rest;
    logic [DATA_W-1:0] in_first;
    logic [1:0]        pend_idx;
    logic [3:0]        pend_rest;
    logic [DATA_W-1:0] pend_data;
    logic              handshake;

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Slot decode: valid mask, popcount, and the next entry to present from
    // either the live inputs (at start) or the pending snapshot (in SEND).
    always_comb begin
        in_arr[0] = in_0;
        in_arr[1] = in_1;
        in_arr[2] = in_2;
        in_arr[3] = in_3;
        in_mask   = {|in_valid_3, |in_valid_2, |in_valid_1, |in_valid_0};
        in_cnt    = {2'b00, in_mask[0]} + {2'b00, in_mask[1]}
                  + {2'b00, in_mask[2]} + {2'b00, in_mask[3]};
        in_idx    = low_idx(in_mask);
        in_rest   = in_mask & (in_mask - 4'd1);
        in_first  = in_arr[in_idx];
        pend_idx  = low_idx(pend);
        pend_rest = pend & (pend - 4'd1);
        pend_data = snap_data[pend_idx];
        handshake = m_valid & m_ready;
    end

    // Control FSM with registered channel and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend       <= 4'd0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            snap_cnt   <= 3'd0;
            empty_snap <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < 4; i++) snap_data[i] <= '0;
`ifdef UNIQUE_SER_PARITY_EN
            m_parity   <= 1'b0;
`endif
        end else begin
            empty_snap <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 4; i++) snap_data[i] <= in_arr[i];
                        snap_cnt <= in_cnt;
                        if (in_mask != 4'd0) begin
                            state   <= SEND;
                            busy    <= 1'b1;
                            m_valid <= 1'b1;
                            m_data  <= in_first;
                            m_last  <= (in_rest == 4'd0);
                            pend    <= in_rest;
`ifdef UNIQUE_SER_PARITY_EN
                            m_parity <= ^in_first;
`endif
                        end else begin
                            empty_snap <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (m_last) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            done    <= 1'b1;
`ifdef UNIQUE_SER_PARITY_EN
                            m_parity <= 1'b0;
`endif
                        end else begin
                            m_data <= pend_data;
                            m_last <= (pend_rest == 4'd0);
                            pend   <= pend_rest;
`ifdef UNIQUE_SER_PARITY_EN
                            m_parity <= ^pend_data;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unique_4_serializer.sv
// Directed testbench for unique_4_serializer.
// Define UNIQUE_SER_PARITY_EN to also exercise m_parity.
module tb_unique_4_serializer;

    logic       clk = 1'b0;
    logic       rst, start, m_ready;
    logic [7:0] in_0, in_1, in_2, in_3;
    logic [1:0] in_valid_0, in_valid_1, in_valid_2, in_valid_3;
    logic [7:0] m_data;
    logic       m_valid, m_last, busy, empty_snap, done;
    logic [2:0] snap_cnt;
`ifdef UNIQUE_SER_PARITY_EN
    logic       m_parity;
`endif

    int n_total = 0;
    int n_pass  = 0;

    unique_4_serializer #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_0       (in_0),
        .in_1       (in_1),
        .in_2       (in_2),
        .in_3       (in_3),
        .in_valid_0 (in_valid_0),
        .in_valid_1 (in_valid_1),
        .in_valid_2 (in_valid_2),
        .in_valid_3 (in_valid_3),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .busy       (busy),
        .snap_cnt   (snap_cnt),
        .empty_snap (empty_snap),
        .done       (done)
`ifdef UNIQUE_SER_PARITY_EN
        ,
        .m_parity   (m_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slots(input logic [7:0] d0, d1, d2, d3,
                             input logic [1:0] v0, v1, v2, v3);
        in_0 = d0; in_1 = d1; in_2 = d2; in_3 = d3;
        in_valid_0 = v0; in_valid_1 = v1; in_valid_2 = v2; in_valid_3 = v3;
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] d, input logic last);
        check({tag, "_valid"}, m_valid, 1'b1);
        check({tag, "_data"},  m_data,  d);
        check({tag, "_last"},  m_last,  last);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_d [4];
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        set_slots(8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00);

        // 1) reset state
        tick(); tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_snap_cnt", snap_cnt, 0);
        check("rst_empty", empty_snap, 0);
        check("rst_done", done, 0);
`ifdef UNIQUE_SER_PARITY_EN
        check("rst_parity", m_parity, 0);
`endif
        rst = 1'b0;
        tick(); tick(); tick();
        check("idle_m_valid", m_valid, 0);
        check("idle_busy", busy, 0);

        // 2) all four valid, m_ready held high
        set_slots(8'd1, 8'd7, 8'd3, 8'd4, 2'b01, 2'b10, 2'b11, 2'b01);
        m_ready = 1'b1; start = 1'b1;
        exp_d[0] = 8'd1; exp_d[1] = 8'd7; exp_d[2] = 8'd3; exp_d[3] = 8'd4;
        tick();
        start = 1'b0;
        check("t2_snap_cnt", snap_cnt, 4);
        check("t2_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            chk_beat($sformatf("t2_beat%0d", i), exp_d[i], i == 3);
            check("t2_no_done", done, 0);
            if (i < 3) tick();
        end
        tick();
        check("t2_done", done, 1);
        check("t2_end_valid", m_valid, 0);
        check("t2_end_busy", busy, 0);

        // 3) sparse slots; start asserted while done is high is accepted
        set_slots(8'd9, 8'd55, 8'd2, 8'd66, 2'b10, 2'b00, 2'b01, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_done_clear", done, 0);
        check("t3_snap_cnt", snap_cnt, 2);
        chk_beat("t3_beat0", 8'd9, 1'b0);
        tick();
        chk_beat("t3_beat1", 8'd2, 1'b1);
        tick();
        check("t3_done", done, 1);
        check("t3_end_valid", m_valid, 0);

        // 4) empty snapshot
        set_slots(8'd5, 8'd6, 8'd7, 8'd8, 2'b00, 2'b00, 2'b00, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_empty", empty_snap, 1);
        check("t4_valid", m_valid, 0);
        check("t4_snap_cnt", snap_cnt, 0);
        check("t4_busy", busy, 0);
        tick();
        check("t4_empty_pulse", empty_snap, 0);
        check("t4_valid2", m_valid, 0);
        check("t4_no_done", done, 0);

        // 5) backpressure, input changes and start pulse mid-stream
        set_slots(8'd1, 8'd7, 8'd3, 8'd4, 2'b11, 2'b11, 2'b11, 2'b11);
        m_ready = 1'b0; start = 1'b1;
        tick();
        chk_beat("t5_beat0", 8'd1, 1'b0);
        set_slots(8'hAA, 8'hBB, 8'hCC, 8'hDD, 2'b01, 2'b00, 2'b00, 2'b00);
        tick();
        start = 1'b0;
        chk_beat("t5_hold0", 8'd1, 1'b0);
        check("t5_snap_cnt", snap_cnt, 4);
        for (int i = 1; i < 4; i++) begin
            m_ready = 1'b1; tick();
            chk_beat($sformatf("t5_beat%0d", i), exp_d[i], i == 3);
            m_ready = 1'b0; tick();
            chk_beat($sformatf("t5_hold%0d", i), exp_d[i], i == 3);
        end
        m_ready = 1'b1; tick();
        check("t5_done", done, 1);
        check("t5_end_valid", m_valid, 0);
        tick();
        check("t5_no_restart", m_valid, 0);
        check("t5_done_pulse", done, 0);

        // 6) reset mid-stream after the second handshake
        set_slots(8'd1, 8'd7, 8'd3, 8'd4, 2'b01, 2'b01, 2'b01, 2'b01);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("t6_beat0", 8'd1, 1'b0);
`ifdef UNIQUE_SER_PARITY_EN
        check("t6_par_01", m_parity, 1);
`endif
        tick();
        chk_beat("t6_beat1", 8'd7, 1'b0);
`ifdef UNIQUE_SER_PARITY_EN
        check("t6_par_07", m_parity, 1);
`endif
        tick();
        chk_beat("t6_beat2", 8'd3, 1'b0);
`ifdef UNIQUE_SER_PARITY_EN
        check("t6_par_03", m_parity, 0);
`endif
        rst = 1'b1;
        tick();
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_snap", snap_cnt, 0);
`ifdef UNIQUE_SER_PARITY_EN
        check("t6_rst_par", m_parity, 0);
`endif
        rst = 1'b0;
        tick();
        check("t6_post_done", done, 0);
        check("t6_post_valid", m_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
